// File: rtl/dbus_responder_pkg.sv
// Shared definitions for the data-side bus responder: FSM states, lane-mask
// encodings, MMIO register offsets and the lane-legality check.
package dbus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] AMP_BYTE = 4'b0001;
  localparam logic [3:0] AMP_HALF = 4'b0011;
  localparam logic [3:0] AMP_WORD = 4'b1111;

  localparam logic [31:0] MMIO_CNT_LO = 32'h0000_0000;
  localparam logic [31:0] MMIO_CNT_HI = 32'h0000_0004;
  localparam logic [31:0] MMIO_TOHOST = 32'h0000_0008;

  // A mask is legal only when it is a naturally aligned byte, half or word.
  function automatic logic lane_ok(input logic [3:0] amp, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (amp == (AMP_BYTE << a)) begin
      ok = 1'b1;
    end else if (!a[0] && (amp == (AMP_HALF << a))) begin
      ok = 1'b1;
    end else if ((a == 2'b00) && (amp == AMP_WORD)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dbus_sram.sv
// Data SRAM: word array with per-byte write enables, synchronous write and
// combinational read of the presented word index.
module dbus_sram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dbus_responder.sv
// Data bus responder: request capture FSM with programmable wait states,
// address/lane decode, SRAM port, cycle counter and tohost register.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [3:0]  amp,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  amp_q, amp_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] tohost_q, tohost_d;
  logic [31:0] rdata_q, rdata_d;

  logic        in_resp_s;
  logic        is_mmio_s;
  logic        is_sram_s;
  logic        word_acc_s;
  logic [31:0] mmio_off_s;
  logic        fault_s;
  logic [31:0] resp_data_s;
  logic        tohost_we_s;
  logic        sram_we_s;
  logic        sram_commit_s;
  logic [31:0] sram_rdata_s;

  assign in_resp_s  = (state_q == ST_RESP);
  assign is_mmio_s  = (addr_q >= MMIO_BASE);
  assign mmio_off_s = addr_q - MMIO_BASE;
  assign is_sram_s  = !is_mmio_s && (addr_q[31:2] < 30'(DEPTH_WORDS));
  assign word_acc_s = (amp_q == AMP_WORD) && (addr_q[1:0] == 2'b00);

  // Next state, wait counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    amp_d   = amp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = memwrite;
          amp_d   = amp;
          addr_d  = addr;
          wdata_d = writedata;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode the captured request into a response and its side effect.
  always_comb begin
    fault_s     = 1'b1;
    resp_data_s = 32'h0;
    tohost_we_s = 1'b0;
    sram_we_s   = 1'b0;
    if (!lane_ok(amp_q, addr_q[1:0])) begin
      fault_s = 1'b1;
    end else if (is_mmio_s) begin
      if (!word_acc_s) begin
        fault_s = 1'b1;
      end else begin
        case (mmio_off_s)
          MMIO_CNT_LO: begin
            if (we_q) begin
              fault_s = 1'b1;
            end else begin
              fault_s     = 1'b0;
              resp_data_s = cyc_q[31:0];
            end
          end
          MMIO_CNT_HI: begin
            if (we_q) begin
              fault_s = 1'b1;
            end else begin
              fault_s     = 1'b0;
              resp_data_s = cyc_q[63:32];
            end
          end
          MMIO_TOHOST: begin
            fault_s = 1'b0;
            if (we_q) begin
              tohost_we_s = 1'b1;
            end else begin
              resp_data_s = tohost_q;
            end
          end
          default: begin
            fault_s = 1'b1;
          end
        endcase
      end
    end else if (is_sram_s) begin
      fault_s = 1'b0;
      if (we_q) begin
        sram_we_s = 1'b1;
      end else begin
        resp_data_s = sram_rdata_s;
      end
    end else begin
      fault_s = 1'b1;
    end
  end

  // Response outputs, held read data, counter and tohost update.
  always_comb begin
    ready    = in_resp_s;
    err      = in_resp_s && fault_s;
    readdata = rdata_q;
    rdata_d  = rdata_q;
    tohost_d = tohost_q;
    cyc_d    = cyc_q + 64'd1;
    if (in_resp_s) begin
      readdata = resp_data_s;
      rdata_d  = resp_data_s;
    end else begin
      readdata = rdata_q;
    end
    if (in_resp_s && tohost_we_s) begin
      tohost_d = wdata_q;
    end else begin
      tohost_d = tohost_q;
    end
  end

  // A reset on the edge leaving RESP must drop the pending store.
  assign sram_commit_s = in_resp_s && sram_we_s && !reset;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      amp_q    <= 4'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      cyc_q    <= 64'd0;
      tohost_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      amp_q    <= amp_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cyc_q    <= cyc_d;
      tohost_q <= tohost_d;
      rdata_q  <= rdata_d;
    end
  end

  dbus_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .we   (sram_commit_s),
    .be   (amp_q),
    .idx  (addr_q[AW+1:2]),
    .wdata(wdata_q),
    .rdata(sram_rdata_s)
  );

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: a WAIT_CYCLES=1 instance and a
// WAIT_CYCLES=0 instance sharing clock, reset and request payload.
module tb_dbus_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        req0;
  logic        memwrite;
  logic [3:0]  amp;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata, readdata0;
  logic        ready, ready0;
  logic        err, err0;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  dbus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .memwrite(memwrite), .amp(amp),
    .addr(addr), .writedata(writedata), .readdata(readdata), .ready(ready), .err(err)
  );

  dbus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .MMIO_BASE(MB)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .memwrite(memwrite), .amp(amp),
    .addr(addr), .writedata(writedata), .readdata(readdata0), .ready(ready0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, wait (bounded) for ready, then idle a cycle.
  task automatic xfer(input bit sel, input logic we, input logic [3:0] a,
                      input logic [31:0] ad, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat);
    logic rdy;
    memwrite  = we;
    amp       = a;
    addr      = ad;
    writedata = wd;
    if (sel) req0 = 1'b1;
    else     req  = 1'b1;
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      rdy = sel ? ready0 : ready;
    end
    chk("ready_seen", {31'd0, rdy}, 32'd1);
    rd = sel ? readdata0 : readdata;
    e  = sel ? err0 : err;
    req  = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    chk("hold_ready", {31'd0, (sel ? ready0 : ready)}, 32'd0);
    chk("hold_err",   {31'd0, (sel ? err0 : err)}, 32'd0);
    chk("hold_rdata", sel ? readdata0 : readdata, rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    reset = 1'b1; req = 1'b0; req0 = 1'b0;
    memwrite = 1'b0; amp = 4'd0; addr = 32'h0; writedata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  {31'd0, ready}, 32'd0);
    chk("rst_err",    {31'd0, err}, 32'd0);
    chk("rst_rdata",  readdata, 32'h0);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_rdata0", readdata0, 32'h0);
    reset = 1'b0;

    // Counter: 100 idle cycles, then accept (+1) and RESP (+1).
    repeat (100) @(negedge clk);
    xfer(1'b0, 1'b0, 4'b1111, MB + 32'h0, 32'h0, rd, e, lat);
    chk("cnt_lo", rd, 32'd102);
    chk("cnt_lo_err", {31'd0, e}, 32'd0);
    xfer(1'b0, 1'b0, 4'b1111, MB + 32'h4, 32'h0, rd, e, lat);
    chk("cnt_hi", rd, 32'd0);

    xfer(1'b0, 1'b1, 4'b1111, MB + 32'h8, 32'h1, rd, e, lat);
    chk("tohost_w_err", {31'd0, e}, 32'd0);
    xfer(1'b0, 1'b0, 4'b1111, MB + 32'h8, 32'h0, rd, e, lat);
    chk("tohost_r", rd, 32'd1);
    xfer(1'b0, 1'b1, 4'b1111, MB + 32'h0, 32'h5, rd, e, lat);
    chk("cnt_lo_w_err", {31'd0, e}, 32'd1);
    xfer(1'b0, 1'b1, 4'b1111, MB + 32'h4, 32'h5, rd, e, lat);
    chk("cnt_hi_w_err", {31'd0, e}, 32'd1);
    xfer(1'b0, 1'b0, 4'b1111, MB + 32'hC, 32'h0, rd, e, lat);
    chk("unmapped_err", {31'd0, e}, 32'd1);
    chk("unmapped_rd", rd, 32'h0);
    xfer(1'b0, 1'b0, 4'b0011, MB + 32'h8, 32'h0, rd, e, lat);
    chk("mmio_half_err", {31'd0, e}, 32'd1);

    xfer(1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, rd, e, lat);
    chk("st_lat", 32'(lat), 32'd2);
    chk("st_err", {31'd0, e}, 32'd0);
    xfer(1'b0, 1'b0, 4'b1111, 32'h10, 32'h0, rd, e, lat);
    chk("ld_lat", 32'(lat), 32'd2);
    chk("ld_data", rd, 32'hDEADBEEF);
    chk("ld_err", {31'd0, e}, 32'd0);

    xfer(1'b0, 1'b1, 4'b1111, 32'h10, 32'h11223344, rd, e, lat);
    xfer(1'b0, 1'b1, 4'b0100, 32'h12, 32'h00AA0000, rd, e, lat);
    chk("stb_err", {31'd0, e}, 32'd0);
    xfer(1'b0, 1'b0, 4'b1111, 32'h10, 32'h0, rd, e, lat);
    chk("stb_data", rd, 32'h11AA3344);

    xfer(1'b0, 1'b1, 4'b0011, 32'h13, 32'h00005555, rd, e, lat);
    chk("badhalf_err", {31'd0, e}, 32'd1);
    chk("badhalf_rd", rd, 32'h0);
    xfer(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, rd, e, lat);
    chk("amp0_err", {31'd0, e}, 32'd1);
    xfer(1'b0, 1'b1, 4'b1100, 32'h12, 32'hBBBB0000, rd, e, lat);
    chk("sth_err", {31'd0, e}, 32'd0);
    xfer(1'b0, 1'b0, 4'b1111, 32'h10, 32'h0, rd, e, lat);
    chk("sth_data", rd, 32'hBBBB3344);

    xfer(1'b0, 1'b0, 4'b1111, 32'h1000, 32'h0, rd, e, lat);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_rd", rd, 32'h0);

    // Reset while the store sits in WAIT: it must vanish without a ready.
    memwrite = 1'b1; amp = 4'b1111; addr = 32'h10; writedata = 32'hCAFEF00D;
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("rstw_ready_a", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("rstw_ready_b", {31'd0, ready}, 32'd0);
    chk("rstw_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    xfer(1'b0, 1'b0, 4'b1111, MB + 32'h0, 32'h0, rd, e, lat);
    chk("rstw_lat", 32'(lat), 32'd2);
    chk("rstw_cnt", rd, 32'd2);
    xfer(1'b0, 1'b0, 4'b1111, MB + 32'h8, 32'h0, rd, e, lat);
    chk("rstw_tohost", rd, 32'd0);
    xfer(1'b0, 1'b0, 4'b1111, 32'h10, 32'h0, rd, e, lat);
    chk("rstw_word", rd, 32'hBBBB3344);

    // Zero wait states.
    xfer(1'b1, 1'b1, 4'b1111, 32'h20, 32'h12345678, rd, e, lat);
    chk("w0_st_lat", 32'(lat), 32'd1);
    chk("w0_st_err", {31'd0, e}, 32'd0);
    xfer(1'b1, 1'b0, 4'b1111, 32'h20, 32'h0, rd, e, lat);
    chk("w0_ld_lat", 32'(lat), 32'd1);
    chk("w0_ld_data", rd, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-side bus responder for the pipelined xgriscv core: it accepts the core's data-memory requests (memwrite, amp byte-lane mask, address, store data) and returns read data after a configurable number of wait states. It contains the data SRAM and a small MMIO window holding a 64-bit cycle counter and a `tohost` register. It sits at the system level beside the instruction memory, driven directly by the core's data port, and adds a req/ready handshake so multi-cycle memories can be modelled.

## Interface
- `DEPTH_WORDS`, 1024: SRAM size in 32-bit words (power of two).
- `WAIT_CYCLES`, 1: extra cycles between request accept and response (0..15).
- `MMIO_BASE`, 32'hFFFF_0000: base address of the MMIO window (64 KiB).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid; sampled only in IDLE.
- `memwrite`  in  1  1 = store, 0 = load.
- `amp`  in  4  byte-lane mask; bit i selects `writedata[8i+7:8i]`.
- `addr`  in  32  byte address.
- `writedata`  in  32  store data, already lane-aligned by the core.
- `readdata`  out  32  full aligned word; valid while `ready`=1.
- `ready`  out  1  one-cycle response pulse.
- `err`  out  1  valid with `ready`; request faulted, no side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `req`=1: capture `memwrite`/`amp`/`addr`/`writedata`; load wait counter with `WAIT_CYCLES`; go to WAIT, or to RESP if `WAIT_CYCLES`=0.
- WAIT: decrement the counter each cycle; when it reaches 0, go to RESP.
- RESP: `ready`=1 for exactly one cycle; store is committed on the edge leaving RESP; return to IDLE.
- `req` is ignored outside IDLE. The core holds the request until `ready`.
- Legal lane masks, checked against `addr[1:0]`:
  - byte: `amp` = 0001<<addr[1:0]
  - half: addr[0]=0, `amp` = 0011<<addr[1:0]
  - word: addr[1:0]=0, `amp` = 1111
  - `amp`=0000 is illegal.
- Any other combination: `err`=1, `readdata`=0, no write.
- Address decode, in priority order:
  - `addr` ≥ `MMIO_BASE`: MMIO.
  - word index `addr[31:2]` < `DEPTH_WORDS`: SRAM.
  - otherwise: `err`=1, `readdata`=0.
- MMIO offsets (word access only; anything else sets `err`):
  - 0x0: cycle counter [31:0], read-only.
  - 0x4: cycle counter [63:32], read-only.
  - 0x8: `tohost`, read/write.
  - Writes to read-only or unmapped offsets set `err`. Unmapped reads set `err`.
- Cycle counter: 64-bit, +1 every cycle, wraps to 0. A read returns its value in the RESP cycle.
- SRAM loads return the full word; lane extraction and sign extension are done by the core.

## Timing
- Latency from the accepting edge to the `ready` cycle is `WAIT_CYCLES`+1 cycles. Back-to-back throughput is one request per `WAIT_CYCLES`+2 cycles.
- A load issued right after a store to the same word returns the new data (the store is committed before IDLE).
- `readdata` holds its last value outside RESP. `err` is 0 outside RESP.
- Reset values: state IDLE, `ready`=0, `err`=0, `readdata`=0, counter=0, `tohost`=0. SRAM contents are not cleared.
- Reset during WAIT/RESP: the pending store is dropped and no `ready` is issued. The first request is accepted on the cycle after `reset` deasserts.

## Structure
- Add to the shared defines package:
  - amp encodings (byte/half/word),
  - MMIO offsets 0x0/0x4/0x8,
  - FSM state encodings.
- Sub-module `dbus_sram`: `DEPTH_WORDS`×32 array with a 4-bit byte-write enable, synchronous write, combinational read of the captured address.
- FSM, decode, lane check, counter and MMIO registers live in the top.

## Test plan
- `WAIT_CYCLES`=1; store word 0xDEADBEEF to 0x10, then load 0x10 → `ready` 2 cycles after each accept; load returns 0xDEADBEEF; `err`=0.
- Store byte `amp`=0100, data 0x00AA0000 to 0x12 over 0x11223344 → word reads 0x11AA3344.
- Half store with `amp`=0011 at addr 0x13 → `err`=1 with `ready`; word unchanged.
- Load 0x0 and 0x4 at `MMIO_BASE` after 100 cycles post-reset → low ≈ 100+latency, high 0. Write 1 to `tohost` and read back 1. Write to offset 0x0 → `err`=1.
- Load at word index `DEPTH_WORDS` → `err`=1, `readdata`=0.
- Assert `reset` during WAIT of a store → no `ready`; target word unchanged; counter=0; `tohost`=0. `WAIT_CYCLES`=0 run → `ready` on the cycle after accept.
